// File: rtl/butterfly_out_collector.sv
// rtl/butterfly_out_collector.sv - re-pairs per-lane real/imag engine outputs into complex rows behind a row FIFO (optional: BFLY_COLLECT_DROP_CNT_EN)
module butterfly_out_collector #(
    parameter int data_width              = 16,
    parameter int parallelism_per_control = 4,
    parameter int fifo_depth              = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         butterfly_start,
    input  logic [15:0]                                  length,
    input  logic [parallelism_per_control-1:0]           dn_serial_vld_A,
    input  logic [data_width*parallelism_per_control-1:0] dn_serial_dat_A,
    input  logic [parallelism_per_control-1:0]           dn_serial_vld_B,
    input  logic [data_width*parallelism_per_control-1:0] dn_serial_dat_B,
    output logic                                         out_vld,
    output logic [2*data_width*parallelism_per_control-1:0] out_dat,
    input  logic                                         out_rdy,
    output logic                                         frame_done,
    output logic                                         err_overrun,
    output logic                                         err_overflow,
    output logic [15:0]                                  err_drop_cnt
);
    localparam int P  = parallelism_per_control;
    localparam int DW = data_width;
    localparam int RW = 2 * DW * P;
    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(fifo_depth);

    logic [P-1:0]          flag_a, flag_b;
    logic [P-1:0][DW-1:0]  hold_a, hold_b;
    logic                  row_done;
    logic                  overrun_hit;
    logic [RW-1:0]         row_packed;

    logic [RW-1:0]         mem [fifo_depth];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  fifo_full, pop, push_ok, drop;

    logic [15:0]           row_cnt, row_cnt_next, length_q;

    // A row completes when every real and imaginary slot holds data
    assign row_done    = (&flag_a) && (&flag_b);
    // A re-write counts as overrun only if the slot is not being freed on this edge
    assign overrun_hit = !row_done && ((|(dn_serial_vld_A & flag_a)) || (|(dn_serial_vld_B & flag_b)));

    // Pack held slots into the engine lane format: {imag, real} per lane
    always_comb begin
        row_packed = '0;
        for (int i = 0; i < P; i++) begin
            row_packed[2*DW*i +: 2*DW] = {hold_b[i], hold_a[i]};
        end
    end

    // Capture stage: a slot accepts data when empty or when the row is draining this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_a <= '0;
            flag_b <= '0;
            hold_a <= '0;
            hold_b <= '0;
        end else if (butterfly_start) begin
            flag_a <= '0;
            flag_b <= '0;
        end else begin
            for (int i = 0; i < P; i++) begin
                if (dn_serial_vld_A[i] && (!flag_a[i] || row_done)) begin
                    hold_a[i] <= dn_serial_dat_A[DW*i +: DW];
                    flag_a[i] <= 1'b1;
                end else if (row_done) begin
                    flag_a[i] <= 1'b0;
                end
                if (dn_serial_vld_B[i] && (!flag_b[i] || row_done)) begin
                    hold_b[i] <= dn_serial_dat_B[DW*i +: DW];
                    flag_b[i] <= 1'b1;
                end else if (row_done) begin
                    flag_b[i] <= 1'b0;
                end
            end
        end
    end

    assign fifo_full = (count == DEPTH_C);
    assign out_vld   = (count != '0);
    assign pop       = out_vld && out_rdy;
    // A full FIFO still accepts a row when the head leaves on the same edge
    assign push_ok   = row_done && (!fifo_full || pop);
    assign drop      = row_done && fifo_full && !pop;
    assign out_dat   = out_vld ? mem[rd_ptr] : '0;

    // Row storage; contents are only observable through the occupancy-gated head
    always_ff @(posedge clk) begin
        if (push_ok && !butterfly_start) begin
            mem[wr_ptr] <= row_packed;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (butterfly_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign row_cnt_next = row_cnt + 16'd1;

    // Frame accounting and sticky error flags; every completion counts, accepted or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt      <= '0;
            length_q     <= '0;
            frame_done   <= 1'b0;
            err_overrun  <= 1'b0;
            err_overflow <= 1'b0;
        end else if (butterfly_start) begin
            row_cnt      <= '0;
            length_q     <= length;
            frame_done   <= 1'b0;
            err_overrun  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (row_done) begin
                if (length_q != '0 && row_cnt_next == length_q) begin
                    frame_done <= 1'b1;
                    row_cnt    <= '0;
                end else begin
                    row_cnt <= row_cnt_next;
                end
            end
            if (overrun_hit) err_overrun  <= 1'b1;
            if (drop)        err_overflow <= 1'b1;
        end
    end

`ifdef BFLY_COLLECT_DROP_CNT_EN
    // Saturating count of rows lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop_cnt <= '0;
        end else if (butterfly_start) begin
            err_drop_cnt <= '0;
        end else if (drop && err_drop_cnt != 16'hFFFF) begin
            err_drop_cnt <= err_drop_cnt + 16'd1;
        end
    end
`else
    assign err_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_butterfly_out_collector.sv
// tb/tb_butterfly_out_collector.sv - directed self-checking bench for butterfly_out_collector
module tb_butterfly_out_collector;
    logic                clk = 1'b0;
    logic                rst_n;
    logic                butterfly_start;
    logic [15:0]         length;
    logic [3:0]          dn_serial_vld_A, dn_serial_vld_B;
    logic [3:0][15:0]    a_d, b_d;
    logic [63:0]         dn_serial_dat_A, dn_serial_dat_B;
    logic                out_vld;
    logic [127:0]        out_dat;
    logic                out_rdy;
    logic                frame_done, err_overrun, err_overflow;
    logic [15:0]         err_drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0]        exp_drop;
    logic [127:0]       exp_row;
    logic [3:0][15:0]   tmp_a;

    assign dn_serial_dat_A = a_d;
    assign dn_serial_dat_B = b_d;

    always #5 clk = ~clk;

    butterfly_out_collector dut (
        .clk(clk), .rst_n(rst_n), .butterfly_start(butterfly_start), .length(length),
        .dn_serial_vld_A(dn_serial_vld_A), .dn_serial_dat_A(dn_serial_dat_A),
        .dn_serial_vld_B(dn_serial_vld_B), .dn_serial_dat_B(dn_serial_dat_B),
        .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
        .frame_done(frame_done), .err_overrun(err_overrun), .err_overflow(err_overflow),
        .err_drop_cnt(err_drop_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb);
        dn_serial_vld_A = va;
        dn_serial_vld_B = vb;
    endtask

    task automatic fill(input logic [15:0] abase, input logic [15:0] bbase);
        for (int i = 0; i < 4; i++) begin
            a_d[i] = abase + 16'(i);
            b_d[i] = bbase + 16'(i);
        end
    endtask

    task automatic fill_k(input int k);
        fill({8'(k), 8'h00}, {1'b1, 7'(k), 8'h00});
    endtask

    function automatic logic [127:0] pack_row(input logic [3:0][15:0] a, input logic [3:0][15:0] b);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = {b[i], a[i]};
        return r;
    endfunction

    function automatic logic [127:0] row_k(input int k);
        logic [3:0][15:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a[i] = {8'(k), 8'(i)};
            b[i] = {1'b1, 7'(k), 8'(i)};
        end
        return pack_row(a, b);
    endfunction

    task automatic start(input logic [15:0] len);
        butterfly_start = 1'b1;
        length = len;
        tick();
        butterfly_start = 1'b0;
    endtask

    initial begin
`ifdef BFLY_COLLECT_DROP_CNT_EN
        exp_drop = 16'd2;
`else
        exp_drop = 16'd0;
`endif
        rst_n = 1'b0; butterfly_start = 1'b0; length = '0; out_rdy = 1'b0;
        drive(4'h0, 4'h0); fill(16'h0, 16'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", err_overrun, 0);
        chk("rst_overflow", err_overflow, 0);
        chk("rst_drop_cnt", err_drop_cnt, 0);

        // full-rate rows, length 3
        start(16'd3);
        out_rdy = 1'b1;
        fill(16'h0000, 16'h0010);
        exp_row = pack_row(a_d, b_d);
        drive(4'hF, 4'hF);
        tick();
        chk("t1_lat_vld", out_vld, 0);
        tick();
        chk("t1_row1_vld", out_vld, 1);
        chk("t1_lane0", out_dat[31:0], 32'h0010_0000);
        chk("t1_row1_dat", out_dat, exp_row);
        chk("t1_fd_r1", frame_done, 0);
        tick();
        drive(4'h0, 4'h0);
        chk("t1_row2_vld", out_vld, 1);
        chk("t1_fd_r2", frame_done, 0);
        tick();
        chk("t1_row3_vld", out_vld, 1);
        chk("t1_row3_dat", out_dat, exp_row);
        chk("t1_fd_r3", frame_done, 1);
        tick();
        chk("t1_empty", out_vld, 0);
        chk("t1_fd_low", frame_done, 0);

        // skewed arrival: A at cycle 0, B at cycle 5
        start(16'd0);
        fill(16'h0A00, 16'h0B00);
        exp_row = pack_row(a_d, b_d);
        drive(4'hF, 4'h0);
        tick();
        drive(4'h0, 4'h0);
        repeat (4) tick();
        chk("t2_pre_b_vld", out_vld, 0);
        drive(4'h0, 4'hF);
        tick();
        drive(4'h0, 4'h0);
        chk("t2_edge5_vld", out_vld, 0);
        tick();
        chk("t2_edge6_vld", out_vld, 1);
        chk("t2_row", out_dat, exp_row);
        chk("t2_overrun", err_overrun, 0);
        tick();
        chk("t2_single_row", out_vld, 0);

        // overrun on A lane 2
        start(16'd0);
        out_rdy = 1'b0;
        a_d[2] = 16'h1111;
        drive(4'b0100, 4'h0);
        tick();
        chk("t3_no_overrun_yet", err_overrun, 0);
        a_d[2] = 16'h2222;
        tick();
        chk("t3_overrun", err_overrun, 1);
        fill(16'h3000, 16'h4000);
        a_d[2] = 16'h2222;
        tmp_a = a_d;
        tmp_a[2] = 16'h1111;
        exp_row = pack_row(tmp_a, b_d);
        drive(4'b1011, 4'hF);
        tick();
        drive(4'h0, 4'h0);
        tick();
        chk("t3_vld", out_vld, 1);
        chk("t3_lane2_real", out_dat[79:64], 16'h1111);
        chk("t3_row", out_dat, exp_row);
        chk("t3_overrun_sticky", err_overrun, 1);

        // overflow: 18 rows into 16 entries with no consumer
        start(16'd0);
        out_rdy = 1'b0;
        for (int r = 1; r <= 18; r++) begin
            fill_k(r);
            drive(4'hF, 4'hF);
            tick();
            if (r == 17) chk("t4_overflow_pre", err_overflow, 0);
        end
        drive(4'h0, 4'h0);
        tick();
        chk("t4_overflow", err_overflow, 1);
        chk("t4_drop_cnt", err_drop_cnt, exp_drop);
        chk("t4_vld", out_vld, 1);
        out_rdy = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("t4_drain%0d", k), out_dat, row_k(k));
            tick();
        end
        chk("t4_drained", out_vld, 0);

        // full FIFO with simultaneous pop and push
        start(16'd0);
        out_rdy = 1'b0;
        for (int r = 1; r <= 16; r++) begin
            fill_k(r);
            drive(4'hF, 4'hF);
            tick();
        end
        drive(4'h0, 4'h0);
        tick();
        fill_k(17);
        drive(4'hF, 4'hF);
        tick();
        drive(4'h0, 4'h0);
        out_rdy = 1'b1;
        tick();
        chk("t5_overflow", err_overflow, 0);
        chk("t5_drop_cnt", err_drop_cnt, 0);
        for (int k = 2; k <= 17; k++) begin
            chk($sformatf("t5_drain%0d", k), out_dat, row_k(k));
            tick();
        end
        chk("t5_drained", out_vld, 0);

        // butterfly_start with queued rows and a half row pending
        start(16'd0);
        out_rdy = 1'b0;
        fill_k(1); drive(4'hF, 4'hF); tick();
        fill_k(2); tick();
        drive(4'h0, 4'h0); tick();
        fill(16'h5555, 16'h0);
        drive(4'hF, 4'h0); tick();
        drive(4'b0001, 4'h0); tick();
        chk("t6_pre_overrun", err_overrun, 1);
        chk("t6_pre_vld", out_vld, 1);
        fill(16'h5555, 16'h9900);
        butterfly_start = 1'b1;
        length = 16'd2;
        drive(4'h0, 4'hF);
        tick();
        butterfly_start = 1'b0;
        chk("t6_vld_clr", out_vld, 0);
        chk("t6_overrun_clr", err_overrun, 0);
        chk("t6_overflow_clr", err_overflow, 0);
        chk("t6_drop_clr", err_drop_cnt, 0);
        fill(16'h7000, 16'h6000);
        exp_row = pack_row(a_d, b_d);
        drive(4'h0, 4'hF); tick();
        drive(4'h0, 4'h0);
        chk("t6_b_only_vld", out_vld, 0);
        drive(4'hF, 4'h0); tick();
        drive(4'h0, 4'h0); tick();
        chk("t6_new_vld", out_vld, 1);
        chk("t6_new_row", out_dat, exp_row);
        chk("t6_fd_r1", frame_done, 0);
        fill_k(3); drive(4'hF, 4'hF); tick();
        drive(4'h0, 4'h0); tick();
        chk("t6_fd_r2", frame_done, 1);
        tick();
        chk("t6_fd_pulse", frame_done, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
